// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control unit for the 64-bit RISC-V datapath.
//   Latency: 4 cycles (branch/lui/jal/shift), 5 (R-type/addi/sd), 7 (ld).
//   No backpressure: outputs follow the state register; unsupported encodings halt until rst.
// Ports: clk/rst (sync, active-high); i31_0 = instruction register; AluIgual = ALU A==B flag;
//   outputs are datapath load enables, mux selects, ALU/shift ops, debug state and halt.
module controle_multiciclo #(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i31_0,
  input  logic        AluIgual,
  output logic        PCwrite,
  output logic        LoadIR,
  output logic        MemRead,
  output logic        MemData_Read,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        loadRegA,
  output logic        loadRegB,
  output logic        loadRegAluOut,
  output logic        loadRegMemData,
  output logic        SelMux2,
  output logic [1:0]  SelMux4,
  output logic [2:0]  SelMuxMem,
  output logic        SelMuxPC,
  output logic [2:0]  AluOperation,
  output logic [1:0]  Shift,
  output logic [4:0]  state,
  output logic        halt
);

  typedef enum logic [4:0] {
    S_RESET    = 5'd0,
    S_FETCH    = 5'd1,
    S_WAIT_IR  = 5'd2,
    S_DECODE   = 5'd3,
    S_EXEC_R   = 5'd4,
    S_EXEC_I   = 5'd5,
    S_WB_ALU   = 5'd6,
    S_ADDR     = 5'd7,
    S_MEM_RD   = 5'd8,
    S_MEM_WAIT = 5'd9,
    S_WB_MEM   = 5'd10,
    S_MEM_WR   = 5'd11,
    S_BRANCH   = 5'd12,
    S_LUI      = 5'd13,
    S_JAL      = 5'd14,
    S_SHIFT    = 5'd15,
    S_ILLEGAL  = 5'd31
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [1:0] hold_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = i31_0[6:0];
  assign funct3 = i31_0[14:12];
  assign funct7 = i31_0[31:25];
  // Register indices and immediates are consumed by the datapath, not here.
  assign unused_fields = ^{i31_0[24:15], i31_0[11:7]};

  // Instruction-class decodes shared by next-state and output logic.
  logic is_add, is_sub, is_and, is_addi, is_ld, is_sd, is_beq, is_bne, shift_bad;
  assign is_add    = (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_and    = (funct3 == 3'b111) && (funct7 == 7'b0000000);
  assign is_addi   = (funct3 == 3'b000);
  assign is_ld     = (opcode == OP_LOAD)  && (funct3 == 3'b011);
  assign is_sd     = (opcode == OP_STORE) && (funct3 == 3'b011);
  assign is_beq    = (funct3 == 3'b000);
  assign is_bne    = (funct3 == 3'b001);
  assign shift_bad = (funct3 == 3'b001) && funct7[5];

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_RESET;
      hold_cnt  <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      // Counts cycles spent in RESET; cleared everywhere else.
      if (cur_state == S_RESET) hold_cnt <= hold_cnt + 2'd1;
      else                      hold_cnt <= 2'd0;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_RESET:   nxt_state = (hold_cnt == HOLD_LAST) ? S_FETCH : S_RESET;
      S_FETCH:   nxt_state = S_WAIT_IR;
      S_WAIT_IR: nxt_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:     nxt_state = S_EXEC_R;
          OP_IMM:   nxt_state = (funct3 == 3'b001 || funct3 == 3'b101) ? S_SHIFT : S_EXEC_I;
          OP_LOAD,
          OP_STORE: nxt_state = S_ADDR;
          OP_BRANCH: nxt_state = S_BRANCH;
          OP_LUI:   nxt_state = S_LUI;
          OP_JAL:   nxt_state = S_JAL;
          default:  nxt_state = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   nxt_state = (is_add || is_sub || is_and) ? S_WB_ALU : S_ILLEGAL;
      S_EXEC_I:   nxt_state = is_addi ? S_WB_ALU : S_ILLEGAL;
      S_WB_ALU:   nxt_state = S_FETCH;
      S_SHIFT:    nxt_state = shift_bad ? S_ILLEGAL : S_FETCH;
      S_ADDR: begin
        if (is_ld)      nxt_state = S_MEM_RD;
        else if (is_sd) nxt_state = S_MEM_WR;
        else            nxt_state = S_ILLEGAL;
      end
      S_MEM_RD:   nxt_state = S_MEM_WAIT;
      S_MEM_WAIT: nxt_state = S_WB_MEM;
      S_WB_MEM:   nxt_state = S_FETCH;
      S_MEM_WR:   nxt_state = S_FETCH;
      S_BRANCH:   nxt_state = (is_beq || is_bne) ? S_FETCH : S_ILLEGAL;
      S_LUI:      nxt_state = S_FETCH;
      S_JAL:      nxt_state = S_FETCH;
      S_ILLEGAL:  nxt_state = S_ILLEGAL;
      default:    nxt_state = S_ILLEGAL;
    endcase
  end

  // ---------------- output logic ----------------
  logic       pc_write_c, load_ir_c, mem_read_c, mem_data_read_c, mem_write_c, reg_write_c;
  logic       load_a_c, load_b_c, load_alu_out_c, load_mem_data_c, sel_mux2_c, sel_mux_pc_c;
  logic [1:0] sel_mux4_c, shift_c;
  logic [2:0] sel_mux_mem_c, alu_op_c;

  always_comb begin
    pc_write_c      = 1'b0;
    load_ir_c       = 1'b0;
    mem_read_c      = 1'b0;
    mem_data_read_c = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    load_a_c        = 1'b0;
    load_b_c        = 1'b0;
    load_alu_out_c  = 1'b0;
    load_mem_data_c = 1'b0;
    sel_mux2_c      = 1'b0;
    sel_mux_pc_c    = 1'b0;
    sel_mux4_c      = 2'b00;
    shift_c         = 2'b00;
    sel_mux_mem_c   = 3'b000;
    alu_op_c        = 3'b000;
    case (cur_state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        sel_mux4_c = 2'b01;
        alu_op_c   = 3'b001;
        pc_write_c = 1'b1;
      end
      S_WAIT_IR: load_ir_c = 1'b1;
      S_DECODE: begin
        // Precompute PC + (imm<<1) into AluOut for a possible branch/jump.
        load_a_c       = 1'b1;
        load_b_c       = 1'b1;
        sel_mux4_c     = 2'b11;
        alu_op_c       = 3'b001;
        load_alu_out_c = 1'b1;
      end
      S_EXEC_R: begin
        sel_mux2_c     = 1'b1;
        load_alu_out_c = 1'b1;
        if (is_add)      alu_op_c = 3'b001;
        else if (is_sub) alu_op_c = 3'b010;
        else if (is_and) alu_op_c = 3'b011;
      end
      S_EXEC_I: begin
        if (is_addi) begin
          sel_mux2_c     = 1'b1;
          sel_mux4_c     = 2'b10;
          alu_op_c       = 3'b001;
          load_alu_out_c = 1'b1;
        end
      end
      S_WB_ALU: reg_write_c = 1'b1;
      S_SHIFT: begin
        if (!shift_bad) begin
          reg_write_c   = 1'b1;
          sel_mux_mem_c = 3'b100;
          if (funct3 == 3'b101) shift_c = funct7[5] ? 2'b10 : 2'b01;
        end
      end
      S_ADDR: begin
        sel_mux2_c     = 1'b1;
        sel_mux4_c     = 2'b10;
        alu_op_c       = 3'b001;
        load_alu_out_c = 1'b1;
      end
      S_MEM_RD:   mem_data_read_c = 1'b1;
      S_MEM_WAIT: begin
        mem_data_read_c = 1'b1;
        load_mem_data_c = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_c   = 1'b1;
        sel_mux_mem_c = 3'b001;
      end
      S_MEM_WR: mem_write_c = 1'b1;
      S_BRANCH: begin
        sel_mux2_c   = 1'b1;
        alu_op_c     = 3'b010;
        sel_mux_pc_c = 1'b1;
        // Only Mealy output: the branch resolves on the live equality flag.
        pc_write_c   = (is_beq && AluIgual) || (is_bne && !AluIgual);
      end
      S_LUI: begin
        reg_write_c   = 1'b1;
        sel_mux_mem_c = 3'b011;
      end
      S_JAL: begin
        // PC was already advanced by 4 in FETCH, so it is the link value.
        reg_write_c   = 1'b1;
        sel_mux_mem_c = 3'b010;
        sel_mux_pc_c  = 1'b1;
        pc_write_c    = 1'b1;
      end
      default: ;
    endcase
  end

  // rst masks every output in the same cycle so an in-flight write never lands.
  always_comb begin
    PCwrite        = pc_write_c      & ~rst;
    LoadIR         = load_ir_c       & ~rst;
    MemRead        = mem_read_c      & ~rst;
    MemData_Read   = mem_data_read_c & ~rst;
    MemWrite       = mem_write_c     & ~rst;
    RegWrite       = reg_write_c     & ~rst;
    loadRegA       = load_a_c        & ~rst;
    loadRegB       = load_b_c        & ~rst;
    loadRegAluOut  = load_alu_out_c  & ~rst;
    loadRegMemData = load_mem_data_c & ~rst;
    SelMux2        = sel_mux2_c      & ~rst;
    SelMuxPC       = sel_mux_pc_c    & ~rst;
    SelMux4        = rst ? 2'b00  : sel_mux4_c;
    Shift          = rst ? 2'b00  : shift_c;
    SelMuxMem      = rst ? 3'b000 : sel_mux_mem_c;
    AluOperation   = rst ? 3'b000 : alu_op_c;
    halt           = (cur_state == S_ILLEGAL) & ~rst;
    state          = cur_state;
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: reset hold, add, ld, beq/bne, srai,
// illegal-opcode halt and reset in the middle of a load.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i31_0;
  logic        AluIgual;
  logic        PCwrite, LoadIR, MemRead, MemData_Read, MemWrite, RegWrite;
  logic        loadRegA, loadRegB, loadRegAluOut, loadRegMemData, SelMux2, SelMuxPC, halt;
  logic [1:0]  SelMux4, Shift;
  logic [2:0]  SelMuxMem, AluOperation;
  logic [4:0]  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst(rst), .i31_0(i31_0), .AluIgual(AluIgual),
    .PCwrite(PCwrite), .LoadIR(LoadIR), .MemRead(MemRead), .MemData_Read(MemData_Read),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
    .loadRegAluOut(loadRegAluOut), .loadRegMemData(loadRegMemData), .SelMux2(SelMux2),
    .SelMux4(SelMux4), .SelMuxMem(SelMuxMem), .SelMuxPC(SelMuxPC),
    .AluOperation(AluOperation), .Shift(Shift), .state(state), .halt(halt)
  );

  // All outputs except state/halt, packed for "everything is zero" checks.
  logic [21:0] all_out;
  assign all_out = {PCwrite, LoadIR, MemRead, MemData_Read, MemWrite, RegWrite,
                    loadRegA, loadRegB, loadRegAluOut, loadRegMemData, SelMux2,
                    SelMux4, SelMuxMem, SelMuxPC, AluOperation, Shift};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i31_0 = 32'h0; AluIgual = 1'b0;

    // ---- reset ----
    tick();
    chk("rst1_state", 32'(state), 32'd0);
    chk("rst1_outs", 32'(all_out), 32'd0);
    tick();
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_outs", 32'(all_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("hold_state", 32'(state), 32'd0);
    chk("hold_outs", 32'(all_out), 32'd0);
    tick();
    chk("fetch_state", 32'(state), 32'd1);
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_pcwrite", 32'(PCwrite), 32'd1);
    chk("fetch_mux4", 32'(SelMux4), 32'd1);
    chk("fetch_aluop", 32'(AluOperation), 32'd1);

    // ---- add x3,x1,x2 ----
    i31_0 = 32'h002081B3;
    tick();
    chk("add_wait_state", 32'(state), 32'd2);
    chk("add_loadir", 32'(LoadIR), 32'd1);
    tick();
    chk("add_decode_state", 32'(state), 32'd3);
    chk("add_decode_loads", 32'({loadRegA, loadRegB, loadRegAluOut}), 32'd7);
    chk("add_decode_mux4", 32'(SelMux4), 32'd3);
    tick();
    chk("add_exec_state", 32'(state), 32'd4);
    chk("add_exec_aluop", 32'(AluOperation), 32'd1);
    chk("add_exec_mux2", 32'(SelMux2), 32'd1);
    tick();
    chk("add_wb_state", 32'(state), 32'd6);
    chk("add_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("add_wb_muxmem", 32'(SelMuxMem), 32'd0);
    tick();
    chk("add_back_fetch", 32'(state), 32'd1);

    // ---- ld x5,8(x1) ----
    i31_0 = 32'h0080B283;
    tick(); chk("ld_s2", 32'(state), 32'd2);
    tick(); chk("ld_s3", 32'(state), 32'd3);
    tick(); chk("ld_s7", 32'(state), 32'd7);
    chk("ld_addr_mux4", 32'(SelMux4), 32'd2);
    chk("ld_addr_lmd", 32'(loadRegMemData), 32'd0);
    tick(); chk("ld_s8", 32'(state), 32'd8);
    chk("ld_rd_memdata", 32'(MemData_Read), 32'd1);
    chk("ld_rd_lmd", 32'(loadRegMemData), 32'd0);
    tick(); chk("ld_s9", 32'(state), 32'd9);
    chk("ld_wait_lmd", 32'(loadRegMemData), 32'd1);
    chk("ld_wait_regwrite", 32'(RegWrite), 32'd0);
    tick(); chk("ld_s10", 32'(state), 32'd10);
    chk("ld_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("ld_wb_muxmem", 32'(SelMuxMem), 32'd1);
    chk("ld_wb_lmd", 32'(loadRegMemData), 32'd0);
    tick(); chk("ld_back_fetch", 32'(state), 32'd1);

    // ---- beq x1,x2 ----
    i31_0 = 32'h00208463;
    AluIgual = 1'b1;
    tick(); tick(); tick();
    chk("beq_state", 32'(state), 32'd12);
    chk("beq_taken_pcwrite", 32'(PCwrite), 32'd1);
    chk("beq_muxpc", 32'(SelMuxPC), 32'd1);
    chk("beq_aluop", 32'(AluOperation), 32'd2);
    AluIgual = 1'b0;
    #1;
    chk("beq_nottaken_pcwrite", 32'(PCwrite), 32'd0);
    tick(); chk("beq_back_fetch", 32'(state), 32'd1);

    // ---- bne x1,x2 ----
    i31_0 = 32'h00209463;
    AluIgual = 1'b1;
    tick(); tick(); tick();
    chk("bne_state", 32'(state), 32'd12);
    chk("bne_eq_pcwrite", 32'(PCwrite), 32'd0);
    AluIgual = 1'b0;
    #1;
    chk("bne_ne_pcwrite", 32'(PCwrite), 32'd1);
    tick(); chk("bne_back_fetch", 32'(state), 32'd1);

    // ---- srai x1,x2,3 ----
    i31_0 = 32'h40315093;
    tick(); tick(); tick();
    chk("srai_state", 32'(state), 32'd15);
    chk("srai_shift", 32'(Shift), 32'd2);
    chk("srai_regwrite", 32'(RegWrite), 32'd1);
    chk("srai_muxmem", 32'(SelMuxMem), 32'd4);
    tick(); chk("srai_back_fetch", 32'(state), 32'd1);

    // ---- illegal opcode ----
    i31_0 = 32'h0000007F;
    tick(); tick(); tick();
    chk("ill_state", 32'(state), 32'd31);
    chk("ill_halt", 32'(halt), 32'd1);
    chk("ill_outs", 32'(all_out), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_sticky", 32'({state, halt, all_out}), {4'd0, 5'd31, 1'b1, 22'd0});
    end
    rst = 1'b1;
    tick();
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_halt", 32'(halt), 32'd0);
    rst = 1'b0;
    tick();
    chk("ill_refetch", 32'(state), 32'd1);

    // ---- reset while a load sits in MEM_WAIT ----
    i31_0 = 32'h0080B283;
    tick(); tick(); tick(); tick(); tick();
    chk("mid_memwait", 32'(state), 32'd9);
    rst = 1'b1;
    #1;
    chk("mid_rst_regwrite_now", 32'(RegWrite), 32'd0);
    chk("mid_rst_outs_now", 32'(all_out), 32'd0);
    tick();
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_regwrite", 32'(RegWrite), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_after_regwrite", 32'(RegWrite), 32'd0);
    tick();
    chk("mid_after_fetch", 32'(state), 32'd1);
    chk("mid_after_fetch_regwrite", 32'(RegWrite), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
